mux8_16_reg: RTL and testbench
==============================

Name: mux8_16_reg

Overview:
- Registered 8:1 multiplexer for a Width-bit data path; default Width is 16.
- sel_i picks one of eight data inputs, a_i through h_i.
- The chosen word is captured on the rising edge of clk_i and driven on y_o.
- Used as a synchronous data-steering stage. Inputs come from upstream logic or a test interface. y_o feeds downstream registered logic.

Parameters:
- Width, 16, bit width of each data input and of y_o; legal range 1..64.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- sel_i  input  3  select code.
- a_i  input  Width  data input 0 (sel_i = 0).
- b_i  input  Width  data input 1 (sel_i = 1).
- c_i  input  Width  data input 2 (sel_i = 2).
- d_i  input  Width  data input 3 (sel_i = 3).
- e_i  input  Width  data input 4 (sel_i = 4).
- f_i  input  Width  data input 5 (sel_i = 5).
- g_i  input  Width  data input 6 (sel_i = 6).
- h_i  input  Width  data input 7 (sel_i = 7).
- y_o  output  Width  registered selected data.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-low.
- Reset assertion (rst_i = 0):
  - y_o goes to 0 immediately, without waiting for a clock edge.
  - All internal registers clear to 0.
  - y_o holds 0 for as long as rst_i stays low.
- Reset release: on a 0->1 transition of rst_i, nothing changes until the next rising clk_i edge. That edge samples normally.
- Selection mapping, fixed: 0->a_i, 1->b_i, 2->c_i, 3->d_i, 4->e_i, 5->f_i, 6->g_i, 7->h_i.
- Decode is fully specified. All eight codes are legal; there is no default or don't-care branch.
- X or Z on sel_i: the registered value is all X in simulation. Synthesis treats the decode as a full case.
- Latency: exactly 1 clock cycle.
  - y_o after rising edge N equals the input chosen by sel_i as sampled at edge N.
  - The data inputs are sampled at the same edge N.
- y_o is a pure register output with no combinational path from any input to y_o.
- Throughput: one new selection per cycle. There is no handshake and no stall.
- sel_i and data may change every cycle. A change between edges has no effect until the next edge.
- Width rules:
  - No arithmetic and no sign handling; bits pass through unchanged.
  - Each output bit i depends only on bit i of the selected input.
- Reset asserted in mid-operation: y_o clears asynchronously and any in-flight value is discarded. After release, the first edge loads a fresh selection.
- Reset and a clock edge in the same timestep: reset wins, and y_o stays 0.

Optional Feature:
- Macro name: MUX8_16_INREG_EN.
- Defined:
  - An extra register stage captures sel_i and a_i..h_i on every rising edge.
  - The mux reads from this stage, so total latency becomes 2 cycles.
  - The stage resets asynchronously to 0 together with y_o.
  - First valid y_o is on the second edge after reset release. The first edge after release outputs the cleared stage, which is a_i-stage = 0, so y_o = 0.
- Not defined: the single-stage, 1-cycle latency behaviour above. No extra flops are inferred.
- Port list and reset behaviour are identical in both builds.

Test Plan:
- Reset check: hold rst_i = 0 for 3 cycles while the data inputs are non-zero -> y_o = 16'h0000 throughout. Also assert rst_i low between clock edges -> y_o = 0 before the next edge.
- Walk every select code: a_i..h_i = 16'h1111, 16'h2222, ..., 16'h8888; step sel_i 0..7, one per cycle -> y_o is 16'h1111..16'h8888, each one cycle after its sel_i value.
- Per-cycle data change: fix sel_i = 5 and change f_i every cycle (16'hA5A5, 16'h5A5A, 16'hFFFF) -> y_o follows with 1-cycle lag. Changes on the other inputs do not affect y_o.
- Back-to-back select changes: alternate sel_i between 0 and 7 each cycle with a_i = 16'h0000 and h_i = 16'hFFFF -> y_o toggles between 16'h0000 and 16'hFFFF every cycle.
- Mid-stream reset: drive rst_i = 0 asynchronously while y_o = 16'h8888, then release -> y_o drops to 0 immediately. y_o stays 0 until the first edge after release, which loads the current selection.
- Macro build with MUX8_16_INREG_EN defined: sel_i = 2, c_i = 16'h3C3C -> y_o = 16'h3C3C on the second edge, not the first.

Source files
------------

// File: rtl/mux8_16_reg.sv
// -----------------------------------------------------------------------------
// mux8_16_reg
//   Registered 8:1 multiplexer. sel_i chooses one of a_i..h_i, and the chosen
//   word is captured on the rising edge of clk_i and driven on y_o. There is no
//   combinational path from any input to y_o.
//
// Optional build macro:
//   MUX8_16_INREG_EN  When defined, sel_i and a_i..h_i are first captured in an
//                     input register stage. The mux reads from that stage, so
//                     the latency becomes 2 cycles. When undefined, the latency
//                     is 1 cycle and no input flops exist.
//
// Parameters:
//   Width   data width of every input and of y_o (1..64, default 16)
//
// Ports:
//   clk_i   in   1      clock, rising edge
//   rst_i   in   1      asynchronous active-low reset; clears every flop to 0
//   sel_i   in   3      select code (0 -> a_i ... 7 -> h_i)
//   a_i..h_i in  Width  data inputs 0..7
//   y_o     out  Width  registered selected word
// -----------------------------------------------------------------------------
module mux8_16_reg #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       sel_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  input  logic [Width-1:0] d_i,
  input  logic [Width-1:0] e_i,
  input  logic [Width-1:0] f_i,
  input  logic [Width-1:0] g_i,
  input  logic [Width-1:0] h_i,
  output logic [Width-1:0] y_o
);

  // Index 0 holds a_i, index 7 holds h_i, matching the select code.
  logic [7:0][Width-1:0] din;
  assign din = {h_i, g_i, f_i, e_i, d_i, c_i, b_i, a_i};

  // Select and data actually seen by the decode.
  logic [2:0]            mux_sel;
  logic [7:0][Width-1:0] mux_din;

`ifdef MUX8_16_INREG_EN
  // Input capture stage: adds one cycle of latency and cuts the path from
  // upstream logic to the decode.
  logic [2:0]            sel_d;
  logic [2:0]            sel_q;
  logic [7:0][Width-1:0] din_d;
  logic [7:0][Width-1:0] din_q;

  always_comb begin
    sel_d = sel_i;
    din_d = din;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_q <= '0;
      din_q <= '0;
    end else begin
      sel_q <= sel_d;
      din_q <= din_d;
    end
  end

  assign mux_sel = sel_q;
  assign mux_din = din_q;
`else
  assign mux_sel = sel_i;
  assign mux_din = din;
`endif

  // All eight codes are decoded explicitly. The all-X preset matters only
  // when sel is X or Z: no item matches, so simulation shows X. Synthesis
  // sees a full case.
  logic [Width-1:0] y_d;
  logic [Width-1:0] y_q;

  always_comb begin
    y_d = {Width{1'bx}};
    case (mux_sel)
      3'd0: y_d = mux_din[0];
      3'd1: y_d = mux_din[1];
      3'd2: y_d = mux_din[2];
      3'd3: y_d = mux_din[3];
      3'd4: y_d = mux_din[4];
      3'd5: y_d = mux_din[5];
      3'd6: y_d = mux_din[6];
      3'd7: y_d = mux_din[7];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: tb/tb_mux8_16_reg.sv
// -----------------------------------------------------------------------------
// tb_mux8_16_reg
//   Self-checking bench for mux8_16_reg. The reference model records the word
//   selected at each rising edge since the last reset, in a short queue.
//   y_o must equal the word recorded LAT edges ago, or 0 if that edge is
//   before the reset.
//   Directed sections also check hand-written literal values.
// -----------------------------------------------------------------------------
module tb_mux8_16_reg;

  localparam int W = 16;
`ifdef MUX8_16_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [2:0]   sel_i = 3'd0;
  logic [W-1:0] din [8];
  logic [W-1:0] y_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mux8_16_reg #(.Width(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sel_i (sel_i),
    .a_i   (din[0]),
    .b_i   (din[1]),
    .c_i   (din[2]),
    .d_i   (din[3]),
    .e_i   (din[4]),
    .f_i   (din[5]),
    .g_i   (din[6]),
    .h_i   (din[7]),
    .y_o   (y_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: y_o=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: words selected at each edge since reset, newest last.
  logic [W-1:0] sampled_q[$];

  always @(posedge clk_i) begin
    if (rst_i) begin
      sampled_q.push_back(din[sel_i]);
      if (sampled_q.size() > LAT) void'(sampled_q.pop_front());
    end
  end

  always @(negedge rst_i) sampled_q.delete();

  function automatic logic [W-1:0] model_y();
    if (sampled_q.size() >= LAT) return sampled_q[sampled_q.size() - LAT];
    return '0;
  endfunction

  // Compare process: checks every falling edge once checking is enabled.
  always @(negedge clk_i) begin
    if (cmp_en) check("cycle_model", y_o, model_y());
  end

  // Hand-written literal expectations. Each call to step() registers the
  // value the inputs select now. After the edge, y_o must show the value
  // registered LAT calls earlier. After a reset, leading zeros stand in for
  // the cleared pipeline.
  logic [W-1:0] lit_q[$];

  task automatic lit_reset();
    lit_q.delete();
    repeat (LAT - 1) lit_q.push_back('0);
  endtask

  task automatic step(input string name, input logic [W-1:0] lit);
    lit_q.push_back(lit);
    @(posedge clk_i);
    #1;
    check(name, y_o, lit_q[lit_q.size() - LAT]);
    while (lit_q.size() > LAT) void'(lit_q.pop_front());
  endtask

  task automatic flush(input string name, input logic [W-1:0] lit);
    repeat (LAT - 1) step(name, lit);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) din[k] = W'(16'hF0F0 ^ k);

    // Reset asserted between edges with non-zero data.
    #2 rst_i = 1'b0;
    cmp_en = 1'b1;
    #1 check("rst_async", y_o, '0);
    repeat (3) begin
      @(posedge clk_i);
      #1 check("rst_hold", y_o, '0);
    end
    #3 rst_i = 1'b1;
    lit_reset();

    // Walk every select code.
    for (int k = 0; k < 8; k++) din[k] = W'(16'h1111 * (k + 1));
    for (int k = 0; k < 8; k++) begin
      sel_i = 3'(k);
      step("walk_sel", W'(16'h1111 * (k + 1)));
    end
    flush("walk_flush", 16'h8888);

    // Mid-stream reset while y_o shows 16'h8888.
    check("pre_rst_value", y_o, 16'h8888);
    #2 rst_i = 1'b0;
    #1 check("rst_midstream", y_o, '0);
    @(posedge clk_i);
    #1 check("rst_mid_hold", y_o, '0);
    #3 rst_i = 1'b1;
    lit_reset();
    #1 check("rst_release_no_edge", y_o, '0);

    // First selection after release: sel=2, c=3C3C.
    sel_i  = 3'd2;
    din[2] = 16'h3C3C;
    step("post_rst_edge1", 16'h3C3C);
    step("post_rst_edge2", 16'h3C3C);

    // Fixed sel=5 with per-cycle data on f_i. Noise on the other inputs.
    sel_i = 3'd5;
    begin
      logic [W-1:0] fvals [3];
      fvals[0] = 16'hA5A5;
      fvals[1] = 16'h5A5A;
      fvals[2] = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 8; j++) if (j != 5) din[j] = W'($urandom());
        din[5] = fvals[k];
        step("sel5_data", fvals[k]);
      end
    end
    flush("sel5_flush", 16'hFFFF);

    // Back-to-back select toggling between 0 and 7.
    din[0] = 16'h0000;
    din[7] = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      sel_i = (k % 2 == 1) ? 3'd7 : 3'd0;
      step("toggle_sel", (k % 2 == 1) ? 16'hFFFF : 16'h0000);
    end
    flush("toggle_flush", 16'hFFFF);

    // Reset asserted in the same timestep as a rising edge: reset wins.
    @(posedge clk_i);
    rst_i = 1'b0;
    #1 check("rst_on_edge", y_o, '0);
    #3 rst_i = 1'b1;
    lit_reset();

    // Randomized traffic with occasional mid-cycle reset pulses.
    repeat (400) begin
      sel_i = 3'($urandom_range(0, 7));
      for (int j = 0; j < 8; j++) din[j] = W'($urandom());
      if ($urandom_range(0, 39) == 0) begin
        rst_i = 1'b0;
        #1 check("rnd_rst", y_o, '0);
        #2 rst_i = 1'b1;
        lit_reset();
      end
      step("rnd_lit", din[sel_i]);
    end

    @(negedge clk_i);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
